// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer.
// State encoding, min:sec limits and wrap/decrement functions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [7:0] MAX_SEC = 8'd59;
  localparam logic [7:0] MAX_MIN = 8'd59;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
  } mmss_t;

  function automatic logic [7:0] inc_wrap(
    input logic [7:0] v,
    input logic [7:0] mx
  );
    return (v >= mx) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic mmss_t dec_time(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec == 8'd0) begin
      r.sec = MAX_SEC;
      r.min = t.min - 8'd1;
    end else begin
      r.sec = t.sec - 8'd1;
    end
    return r;
  endfunction

  function automatic logic is_zero(input mmss_t t);
    return (t.min == 8'd0) && (t.sec == 8'd0);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: FSM, time, preset and alarm counter.
// Ports: clk/reset_p/tick, qualified button pulses, time + state flags.
module timer_channel
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick,
  input  logic       i_start,
  input  logic       i_inc_sec,
  input  logic       i_inc_min,
  input  logic       i_off,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic       o_running,
  output logic       o_alarm
);

  localparam int ACW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [ACW-1:0] ACNT_LAST = ACW'(ALARM_TICKS - 1);

  state_e          r_state, w_state;
  mmss_t           r_time, w_time;
  mmss_t           r_pre, w_pre;
  logic [ACW-1:0]  r_acnt, w_acnt;
  mmss_t           w_dec;
  logic            w_any_btn;

  assign w_dec     = dec_time(r_time);
  assign w_any_btn = i_off | i_start | i_inc_sec | i_inc_min;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state <= ST_IDLE;
      r_time  <= '0;
      r_pre   <= '0;
      r_acnt  <= '0;
    end else begin
      r_state <= w_state;
      r_time  <= w_time;
      r_pre   <= w_pre;
      r_acnt  <= w_acnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_time  = r_time;
    w_pre   = r_pre;
    w_acnt  = r_acnt;
    unique case (r_state)
      ST_IDLE: begin
        if (i_off) begin
          w_time = r_pre;
        end else if (i_start && !is_zero(r_time)) begin
          w_state = ST_RUN;
          w_pre   = r_time;
        end else begin
          if (i_inc_sec)
            w_time.sec = inc_wrap(r_time.sec, MAX_SEC);
          if (i_inc_min)
            w_time.min = inc_wrap(r_time.min, MAX_MIN);
        end
      end
      ST_RUN: begin
        if (i_off) begin
          w_state = ST_IDLE;
          w_time  = r_pre;
        end else if (i_start) begin
          w_state = ST_PAUSE;
        end else if (tick) begin
          w_time = w_dec;
          // expiry: alarm shows 00:00 from the same edge
          if (is_zero(w_dec)) begin
            w_state = ST_ALARM;
            w_acnt  = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (i_off) begin
          w_state = ST_IDLE;
          w_time  = r_pre;
        end else if (i_start) begin
          w_state = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (w_any_btn) begin
          w_state = ST_IDLE;
          w_time  = r_pre;
        end else if (tick) begin
          if (r_acnt == ACNT_LAST) begin
            w_state = ST_IDLE;
            w_time  = r_pre;
          end else begin
            w_acnt = r_acnt + 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign o_sec     = r_time.sec;
  assign o_min     = r_time.min;
  assign o_running = (r_state == ST_RUN);
  assign o_alarm   = (r_state == ST_ALARM);

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH countdown channels sharing one tick prescaler and button set.
// Ports: buttons in, selected channel time + per-channel flags out.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int ALARM_TICKS = 30,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              enable,
  input  logic              btn_sel,
  input  logic              btn_start,
  input  logic              inc_sec,
  input  logic              inc_min,
  input  logic              alarm_off,
  output logic [CH_W-1:0]   sel_ch,
  output logic [7:0]        sec,
  output logic [7:0]        min,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] alarm,
  output logic              alarm_any
);

  localparam int PS_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PS_W   = (PS_MAX > 0) ? $clog2(PS_MAX + 1) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PS_MAX);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic [PS_W-1:0] r_ps;
  logic            w_tick;
  logic [CH_W-1:0] r_sel;
  logic [7:0]      w_sec [NUM_CH];
  logic [7:0]      w_min [NUM_CH];

  assign w_tick = (r_ps == PS_LAST);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      r_ps <= '0;
    else if (w_tick)
      r_ps <= '0;
    else
      r_ps <= r_ps + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      r_sel <= '0;
    else if (enable && btn_sel)
      r_sel <= (r_sel == CH_LAST) ? '0 : r_sel + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_hit;
    // buttons in the btn_sel cycle still target the old channel
    assign w_hit = enable && (r_sel == CH_W'(g));

    timer_channel #(
      .ALARM_TICKS(ALARM_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset_p   (reset_p),
      .tick      (w_tick),
      .i_start   (w_hit & btn_start),
      .i_inc_sec (w_hit & inc_sec),
      .i_inc_min (w_hit & inc_min),
      .i_off     (w_hit & alarm_off),
      .o_sec     (w_sec[g]),
      .o_min     (w_min[g]),
      .o_running (running[g]),
      .o_alarm   (alarm[g])
    );
  end

  assign sel_ch    = r_sel;
  assign sec       = w_sec[r_sel];
  assign min       = w_min[r_sel];
  assign alarm_any = |alarm;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer (4 ch, 10 clk/tick, 3 alarm ticks).
// Inputs change on negedge; outputs are checked on negedge.
module tb_multi_channel_timer;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       enable = 1'b1;
  logic       btn_sel = 1'b0;
  logic       btn_start = 1'b0;
  logic       inc_sec = 1'b0;
  logic       inc_min = 1'b0;
  logic       alarm_off = 1'b0;
  logic [1:0] sel_ch;
  logic [7:0] sec;
  logic [7:0] min;
  logic [3:0] running;
  logic [3:0] alarm;
  logic       alarm_any;

  int n_chk = 0;
  int n_fail = 0;
  int b_cnt;

  multi_channel_timer #(
    .NUM_CH(4),
    .CLK_HZ(10),
    .TICK_HZ(1),
    .ALARM_TICKS(3)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .enable(enable),
    .btn_sel(btn_sel),
    .btn_start(btn_start),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .alarm_off(alarm_off),
    .sel_ch(sel_ch),
    .sec(sec),
    .min(min),
    .running(running),
    .alarm(alarm),
    .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  // tick expected in any cycle where this reference count is 9
  always @(posedge clk or posedge reset_p) begin
    if (reset_p)
      b_cnt <= 0;
    else
      b_cnt <= (b_cnt == 9) ? 0 : b_cnt + 1;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // m = {alarm_off, inc_min, inc_sec, btn_start, btn_sel}
  task automatic press(input logic [4:0] m);
    btn_sel   = m[0];
    btn_start = m[1];
    inc_sec   = m[2];
    inc_min   = m[3];
    alarm_off = m[4];
    @(negedge clk);
    btn_sel   = 1'b0;
    btn_start = 1'b0;
    inc_sec   = 1'b0;
    inc_min   = 1'b0;
    alarm_off = 1'b0;
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      while (b_cnt != 9) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  localparam logic [4:0] SEL   = 5'b00001;
  localparam logic [4:0] START = 5'b00010;
  localparam logic [4:0] ISEC  = 5'b00100;
  localparam logic [4:0] IMIN  = 5'b01000;
  localparam logic [4:0] OFF   = 5'b10000;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_sec", sec, 0);
    chk("rst_run", running, 0);
    chk("rst_any", alarm_any, 0);
    reset_p = 1'b0;

    // 1: 01:02 countdown, alarm, auto-silence with preset reload
    press(IMIN);
    press_n(ISEC, 2);
    chk("t1_sec", sec, 2);
    chk("t1_min", min, 1);
    press(START);
    chk("t1_run", running, 1);
    wait_ticks(61);
    chk("t1_s61", sec, 1);
    chk("t1_m61", min, 0);
    wait_ticks(1);
    chk("t1_alm", alarm, 1);
    chk("t1_run0", running, 0);
    chk("t1_s0", sec, 0);
    chk("t1_m0", min, 0);
    wait_ticks(2);
    chk("t1_alm2", alarm, 1);
    wait_ticks(1);
    chk("t1_silent", alarm, 0);
    chk("t1_rs", sec, 2);
    chk("t1_rm", min, 1);

    // 2: two channels, background alarm, enable gating
    do_reset();
    press_n(ISEC, 5);
    press(START);
    press(SEL);
    chk("t2_sel", sel_ch, 1);
    press_n(ISEC, 10);
    press(START);
    wait_ticks(5);
    chk("t2_alm", alarm, 4'b0001);
    chk("t2_run", running, 4'b0010);
    chk("t2_sec", sec, 5);
    enable = 1'b0;
    wait_ticks(2);
    press(START | OFF | SEL);
    chk("t2_gate_sel", sel_ch, 1);
    wait_ticks(3);
    chk("t2_run1", running, 0);
    chk("t2_alm1", alarm, 4'b0010);
    chk("t2_any", alarm_any, 1);
    chk("t2_sec0", sec, 0);
    enable = 1'b1;

    // 3: pause coinciding with tick, resume
    do_reset();
    press_n(ISEC, 3);
    press(START);
    while (b_cnt != 9) @(negedge clk);
    chk("t3_pre", sec, 3);
    press(START);
    chk("t3_pause", running, 0);
    chk("t3_sec", sec, 3);
    wait_ticks(4);
    chk("t3_frozen", sec, 3);
    press(START);
    chk("t3_resume", running, 1);
    wait_ticks(1);
    chk("t3_dec", sec, 2);
    press(OFF);
    chk("t3_off_run", running, 0);
    chk("t3_off_sec", sec, 3);

    // 4: start at 00:00 ignored, sec wrap
    do_reset();
    press(START);
    chk("t4_idle", running, 0);
    press_n(ISEC, 59);
    chk("t4_s59", sec, 59);
    press(ISEC);
    chk("t4_wrap", sec, 0);
    chk("t4_min", min, 0);

    // 5: select and inc in same cycle hit the old channel
    do_reset();
    press_n(SEL, 3);
    chk("t5_sel3", sel_ch, 3);
    press(SEL | ISEC);
    chk("t5_sel0", sel_ch, 0);
    chk("t5_ch0", sec, 0);
    press_n(SEL, 3);
    chk("t5_ch3", sec, 1);

    // 6: async reset mid-run
    do_reset();
    press(IMIN);
    press_n(ISEC, 2);
    press(START);
    press(SEL);
    press(ISEC);
    press(START);
    chk("t6_run", running, 4'b0011);
    chk("t6_sec1", sec, 1);
    #2 reset_p = 1'b1;
    #1;
    chk("t6_sel", sel_ch, 0);
    chk("t6_sec", sec, 0);
    chk("t6_min", min, 0);
    chk("t6_runz", running, 0);
    chk("t6_alm", alarm, 0);
    @(negedge clk);
    reset_p = 1'b0;
    press(START);
    chk("t6_ign", running, 0);
    chk("t6_after", sec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor to the single cook timer: NUM_CH independent countdown channels (min:sec) share one tick prescaler and one button set.
- The selected channel is edited and controlled by buttons. Every channel keeps counting in the background, even when the mode is not enabled.
- It sits behind the button_cntr pulse outputs and in front of bin_to_dec/FND_cntr. Each channel adds pause, preset reload and auto-silence of its alarm.

Parameters:
- NUM_CH, 4, number of independent timer channels (2..8)
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1, countdown rate; prescaler terminal count = CLK_HZ/TICK_HZ-1
- ALARM_TICKS, 30, ticks an alarm stays active before auto-silence
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset_p  in  1  reset, asynchronous, active-high
- enable  in  1  mode active; gates all button inputs only
- btn_sel  in  1  one-cycle pulse: select next channel
- btn_start  in  1  one-cycle pulse: start/pause selected channel
- inc_sec  in  1  one-cycle pulse: +1 second on selected channel
- inc_min  in  1  one-cycle pulse: +1 minute on selected channel
- alarm_off  in  1  one-cycle pulse: cancel/acknowledge selected channel
- sel_ch  out  CH_W  currently selected channel
- sec  out  8  seconds of selected channel (binary 0..59)
- min  out  8  minutes of selected channel (binary 0..59)
- running  out  NUM_CH  per-channel RUN state flag
- alarm  out  NUM_CH  per-channel ALARM state flag
- alarm_any  out  1  OR of alarm

Behaviour:
- Reset (async, any time, including mid-count): prescaler=0, sel_ch=0, every channel IDLE, time=00:00, preset=00:00, alarm counter=0. All outputs 0.
- Prescaler: free-running and independent of enable. tick is a single-cycle pulse when count = CLK_HZ/TICK_HZ-1, after which the count wraps to 0. All channels see the same tick.
- Button gating:
  - A button pulse acts only when enable=1 and only on the channel equal to sel_ch in that cycle.
  - btn_sel increments sel_ch, wrapping NUM_CH-1 -> 0. The new selection is visible next cycle; other buttons in the same cycle apply to the old channel.
- Within a channel, same-cycle priority is alarm_off > btn_start > inc_min/inc_sec. inc_min and inc_sec may apply together.
- Channel FSM, 2-bit state:
  - IDLE:
    - inc_sec: sec 59->0 else +1. inc_min: min 59->0 else +1.
    - btn_start with time != 00:00 -> RUN and preset <= time. btn_start at 00:00 is ignored.
    - alarm_off -> time <= preset.
  - RUN:
    - On tick: if sec==0, sec=59 and min-1; else sec-1.
    - If the decremented value is 00:00 -> ALARM in the next cycle, alarm counter=0.
    - btn_start -> PAUSE; it wins over a coincident tick (no decrement).
    - alarm_off -> IDLE with time <= preset. inc_* ignored.
  - PAUSE:
    - Time frozen.
    - btn_start -> RUN; no decrement in the transition cycle even if tick=1.
    - alarm_off -> IDLE with time <= preset. inc_* ignored.
  - ALARM:
    - alarm bit=1. Counter increments per tick.
    - alarm_off, btn_start, inc_sec or inc_min -> IDLE with time <= preset. The button's own action is discarded.
    - Counter reaching ALARM_TICKS-1 on a tick -> IDLE with time <= preset (auto-silence).
- Entry to RUN is the only path that writes preset.
- Timing:
  - running and alarm are registered state decodes (1-cycle latency from the causing event).
  - sec/min are a combinational mux of the registered values of channel sel_ch.
- Background channels continue RUN/ALARM progression regardless of enable or selection.

Decomposition:
- Package timer_pkg:
  - State constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_ALARM=2'd3.
  - MAX_SEC=59, MAX_MIN=59.
  - Decrement/increment-with-wrap functions.
- Sub-module timer_channel holds one channel's FSM, time, preset and alarm counter.
  - Inputs: clk, reset_p, tick, and start/inc_sec/inc_min/off already qualified by enable and selection.
  - Instantiated NUM_CH times in a generate loop.
- Prescaler, selector and output mux stay in the top.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1, ALARM_TICKS=3.
1. Reset, then inc_min x1 and inc_sec x2 on ch0 -> sec=2, min=1. btn_start -> running[0]=1; after 62 ticks alarm[0]=1, display 00:00; 3 ticks later alarm[0]=0 and display 01:02 (preset reload).
2. ch0 set 00:05 and started; btn_sel -> sel_ch=1. Set ch1 00:10 and start it. After 5 ticks alarm=4'b0001 with ch1 showing 00:05; enable=0 for 5 more ticks -> running[1]=0, alarm[1]=1.
3. RUN at 00:03, btn_start coinciding with tick -> PAUSE, display stays 00:03. Wait 4 ticks -> unchanged. btn_start -> resumes, 00:02 at next tick.
4. IDLE at 00:00, btn_start -> stays IDLE, running=0. inc_sec x60 -> sec wraps to 0, min unchanged.
5. btn_sel and inc_sec in the same cycle with sel_ch=3, NUM_CH=4 -> ch3 sec+1, sel_ch=0 next cycle.
6. reset_p asserted mid-RUN, between clk edges -> all outputs 0 immediately. After release, btn_start on ch0 is ignored (00:00).
